// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard/sequencing controller.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALTED   = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO        = 5'd0;
    localparam int         DEF_MEM_TIMEOUT = 16;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller: drives stage-register enables/clears and the PC
// enable for the 5-stage pipeline, with saturating stall and flush counters.
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic             ID_uses_rs,
    input  logic             ID_uses_rt,
    input  logic             EX_mem_read,
    input  logic [4:0]       EX_rd,
    input  logic             EX_mispredict,
    input  logic             MEM_req,
    input  logic             MEM_ack,
    input  logic             WB_halt,
    input  logic             resume,
    output logic             PC_ENABLE,
    output logic             IF_ID_ENABLE,
    output logic             IF_ID_CLR,
    output logic             ID_EX_ENABLE,
    output logic             ID_EX_CLR,
    output logic             EX_MEM_ENABLE,
    output logic             MEM_WB_ENABLE,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
    output state_t           dbg_state
);

    // Entering MEM_WAIT already counts as wait cycle 1, so the last legal count is one less.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state, next_state;
    logic [7:0] wait_cnt, wait_nxt;
    logic       mem_err_nxt;
    logic       load_use;
    logic       apply_run;
    logic       flush;
    logic       stall;

    assign load_use = EX_mem_read && (EX_rd != REG_ZERO) &&
                      ((ID_uses_rs && (ID_rs == EX_rd)) || (ID_uses_rt && (ID_rt == EX_rd)));

    assign dbg_state = state;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
            mem_err  <= 1'b0;
        end else begin
            state    <= next_state;
            wait_cnt <= wait_nxt;
            mem_err  <= mem_err_nxt;
        end
    end

    // Memory handshake: MEM holds MEM_req until MEM_ack; an access completes in the
    // cycle where both are high, so req with ack together never stalls.
    always_comb begin
        PC_ENABLE     = 1'b1;
        IF_ID_ENABLE  = 1'b1;
        IF_ID_CLR     = 1'b0;
        ID_EX_ENABLE  = 1'b1;
        ID_EX_CLR     = 1'b0;
        EX_MEM_ENABLE = 1'b1;
        MEM_WB_ENABLE = 1'b1;
        halted        = 1'b0;
        next_state    = state;
        wait_nxt      = wait_cnt;
        mem_err_nxt   = mem_err;
        flush         = 1'b0;
        apply_run     = (state == RUN) || ((state == MEM_WAIT) && MEM_ack);

        if (apply_run) begin
            next_state = RUN;
            if (WB_halt) begin
                {PC_ENABLE, IF_ID_ENABLE, ID_EX_ENABLE, EX_MEM_ENABLE, MEM_WB_ENABLE} = '0;
                next_state = HALTED;
            end else if (MEM_req && !MEM_ack) begin
                {PC_ENABLE, IF_ID_ENABLE, ID_EX_ENABLE, EX_MEM_ENABLE, MEM_WB_ENABLE} = '0;
                next_state = MEM_WAIT;
                wait_nxt   = 8'd1;
            end else if (EX_mispredict) begin
                // The load-use victim, if any, sits in IF/ID and is flushed anyway.
                IF_ID_CLR = 1'b1;
                ID_EX_CLR = 1'b1;
                flush     = 1'b1;
            end else if (load_use) begin
                PC_ENABLE    = 1'b0;
                IF_ID_ENABLE = 1'b0;
                ID_EX_CLR    = 1'b1;
            end
        end else begin
            {PC_ENABLE, IF_ID_ENABLE, ID_EX_ENABLE, EX_MEM_ENABLE, MEM_WB_ENABLE} = '0;
            unique case (state)
                MEM_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        mem_err_nxt = 1'b1;
                        next_state  = HALTED;
                    end else begin
                        wait_nxt = wait_cnt + 8'd1;
                    end
                end
                HALTED: begin
                    halted = 1'b1;
                    if (resume) next_state = RUN;
                end
                default: next_state = RUN;
            endcase
        end

        if (!RST_N) begin
            {PC_ENABLE, IF_ID_ENABLE, ID_EX_ENABLE, EX_MEM_ENABLE, MEM_WB_ENABLE} = '0;
            IF_ID_CLR = 1'b1;
            ID_EX_CLR = 1'b1;
            halted    = 1'b0;
            flush     = 1'b0;
        end
    end

    assign stall = RST_N && (state != HALTED) && !PC_ENABLE;

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .RST_N (RST_N),
        .inc   (stall),
        .count (stall_cycles)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .CLK   (CLK),
        .RST_N (RST_N),
        .inc   (flush),
        .count (flush_events)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scenario bench for pipeline_ctrl: per-cycle expected control vectors go through a
// queue; counters use a narrow width so saturation is reachable.
module tb_pipeline_ctrl;
    import pipe_pkg::*;

    localparam int CNT_W       = 4;
    localparam int MEM_TIMEOUT = 16;

    // {PC, IF_ID_EN, IF_ID_CLR, ID_EX_EN, ID_EX_CLR, EX_MEM_EN, MEM_WB_EN, halted}
    localparam logic [7:0] CTRL_RUN      = 8'b1101_0110;
    localparam logic [7:0] CTRL_FROZEN   = 8'b0000_0000;
    localparam logic [7:0] CTRL_HALT     = 8'b0000_0001;
    localparam logic [7:0] CTRL_RESET    = 8'b0010_1000;
    localparam logic [7:0] CTRL_LOAD_USE = 8'b0001_1110;
    localparam logic [7:0] CTRL_FLUSH    = 8'b1111_1110;

    logic             CLK = 1'b0;
    logic             RST_N = 1'b1;
    logic [4:0]       ID_rs, ID_rt, EX_rd;
    logic             ID_uses_rs, ID_uses_rt, EX_mem_read, EX_mispredict;
    logic             MEM_req, MEM_ack, WB_halt, resume;
    logic             PC_ENABLE, IF_ID_ENABLE, IF_ID_CLR, ID_EX_ENABLE, ID_EX_CLR;
    logic             EX_MEM_ENABLE, MEM_WB_ENABLE, halted, mem_err;
    logic [CNT_W-1:0] stall_cycles, flush_events;
    state_t           dbg_state;

    logic [7:0]       exp_q[$];
    logic [CNT_W-1:0] exp_stall, exp_flush;
    logic             exp_err;
    int               checks = 0;
    int               errors = 0;

    pipeline_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .ID_rs         (ID_rs),
        .ID_rt         (ID_rt),
        .ID_uses_rs    (ID_uses_rs),
        .ID_uses_rt    (ID_uses_rt),
        .EX_mem_read   (EX_mem_read),
        .EX_rd         (EX_rd),
        .EX_mispredict (EX_mispredict),
        .MEM_req       (MEM_req),
        .MEM_ack       (MEM_ack),
        .WB_halt       (WB_halt),
        .resume        (resume),
        .PC_ENABLE     (PC_ENABLE),
        .IF_ID_ENABLE  (IF_ID_ENABLE),
        .IF_ID_CLR     (IF_ID_CLR),
        .ID_EX_ENABLE  (ID_EX_ENABLE),
        .ID_EX_CLR     (ID_EX_CLR),
        .EX_MEM_ENABLE (EX_MEM_ENABLE),
        .MEM_WB_ENABLE (MEM_WB_ENABLE),
        .halted        (halted),
        .mem_err       (mem_err),
        .stall_cycles  (stall_cycles),
        .flush_events  (flush_events),
        .dbg_state     (dbg_state)
    );

    // clock / watchdog
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        ID_rs = 5'd0; ID_rt = 5'd0; EX_rd = 5'd0;
        ID_uses_rs = 1'b0; ID_uses_rt = 1'b0; EX_mem_read = 1'b0;
        EX_mispredict = 1'b0; MEM_req = 1'b0; MEM_ack = 1'b0;
        WB_halt = 1'b0; resume = 1'b0;
    endtask

    function automatic logic [7:0] ctrl_now();
        return {PC_ENABLE, IF_ID_ENABLE, IF_ID_CLR, ID_EX_ENABLE, ID_EX_CLR,
                EX_MEM_ENABLE, MEM_WB_ENABLE, halted};
    endfunction

    // One clock: queue the expected vector, compare at the falling edge, land 1 after the rise.
    task automatic step(input string name, input logic [7:0] exp);
        logic [7:0] want, got;
        exp_q.push_back(exp);
        if (RST_N && !exp[7] && !exp[0] && (exp_stall != {CNT_W{1'b1}}))
            exp_stall = exp_stall + 1'b1;
        @(negedge CLK);
        got  = ctrl_now();
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: ctrl=%b expected %b", name, got, want);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic check_counts(input string name);
        checks++;
        if (stall_cycles !== exp_stall) begin
            errors++;
            $display("FAIL %s stall_cycles: got %0d expected %0d", name, stall_cycles, exp_stall);
        end
        checks++;
        if (flush_events !== exp_flush) begin
            errors++;
            $display("FAIL %s flush_events: got %0d expected %0d", name, flush_events, exp_flush);
        end
        checks++;
        if (mem_err !== exp_err) begin
            errors++;
            $display("FAIL %s mem_err: got %b expected %b", name, mem_err, exp_err);
        end
    endtask

    // Asserts reset between edges and checks outputs before any clock edge arrives.
    task automatic apply_reset(input string name);
        logic [7:0] want, got;
        RST_N = 1'b0;
        clear_inputs();
        #2;
        exp_q.push_back(CTRL_RESET);
        got  = ctrl_now();
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: ctrl=%b expected %b", name, got, want);
        end
        exp_stall = '0;
        exp_flush = '0;
        exp_err   = 1'b0;
        check_counts(name);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset("reset_hold");
        step("reset_release_0", CTRL_RUN);
        step("reset_release_1", CTRL_RUN);
        check_counts("reset_release");
    endtask

    task automatic test_load_use();
        logic lu;
        apply_reset("load_use_reset");
        EX_mem_read = 1'b1; EX_rd = 5'd8; ID_rs = 5'd8; ID_uses_rs = 1'b1;
        step("load_use_rs", CTRL_LOAD_USE);
        EX_mem_read = 1'b0; EX_rd = 5'd0;
        step("load_use_released", CTRL_RUN);
        check_counts("load_use_rs");
        EX_mem_read = 1'b1; EX_rd = 5'd0; ID_rs = 5'd0;
        step("load_rd_zero", CTRL_RUN);
        ID_uses_rs = 1'b0; ID_rt = 5'd5; ID_uses_rt = 1'b1; EX_rd = 5'd5;
        step("load_use_rt", CTRL_LOAD_USE);
        ID_uses_rt = 1'b0;
        step("rt_not_used", CTRL_RUN);
        for (int i = 0; i < 12; i++) begin
            ID_rs       = 5'($urandom_range(0, 3));
            ID_rt       = 5'($urandom_range(0, 3));
            EX_rd       = 5'($urandom_range(0, 3));
            ID_uses_rs  = 1'($urandom_range(0, 1));
            ID_uses_rt  = 1'($urandom_range(0, 1));
            EX_mem_read = 1'($urandom_range(0, 1));
            lu = EX_mem_read && (EX_rd != 5'd0) &&
                 ((ID_uses_rs && ID_rs == EX_rd) || (ID_uses_rt && ID_rt == EX_rd));
            step("load_use_random", lu ? CTRL_LOAD_USE : CTRL_RUN);
        end
        clear_inputs();
        check_counts("load_use_random");
    endtask

    task automatic test_mispredict();
        apply_reset("mispredict_reset");
        EX_mem_read = 1'b1; EX_rd = 5'd8; ID_rs = 5'd8; ID_uses_rs = 1'b1;
        EX_mispredict = 1'b1;
        exp_flush = exp_flush + 1'b1;
        step("mispredict_with_load_use", CTRL_FLUSH);
        clear_inputs();
        check_counts("mispredict_with_load_use");
        EX_mispredict = 1'b1;
        exp_flush = exp_flush + 1'b1;
        step("mispredict_b2b_0", CTRL_FLUSH);
        exp_flush = exp_flush + 1'b1;
        step("mispredict_b2b_1", CTRL_FLUSH);
        clear_inputs();
        step("mispredict_done", CTRL_RUN);
        check_counts("mispredict_b2b");
    endtask

    task automatic test_mem_wait();
        apply_reset("mem_wait_reset");
        MEM_req = 1'b1;
        step("mem_wait_0", CTRL_FROZEN);
        EX_mispredict = 1'b1;
        step("mem_wait_ignore_mispredict", CTRL_FROZEN);
        EX_mispredict = 1'b0;
        step("mem_wait_2", CTRL_FROZEN);
        MEM_ack = 1'b1;
        step("mem_ack_resume", CTRL_RUN);
        step("mem_req_ack_same", CTRL_RUN);
        clear_inputs();
        check_counts("mem_wait_3");
        MEM_req = 1'b1;
        step("mem_wait_again", CTRL_FROZEN);
        MEM_ack = 1'b1;
        EX_mem_read = 1'b1; EX_rd = 5'd3; ID_rt = 5'd3; ID_uses_rt = 1'b1;
        step("mem_ack_with_load_use", CTRL_LOAD_USE);
        clear_inputs();
        step("mem_ack_after", CTRL_RUN);
        check_counts("mem_ack_load_use");
        MEM_req = 1'b1;
        step("mem_wait_pre_reset_0", CTRL_FROZEN);
        step("mem_wait_pre_reset_1", CTRL_FROZEN);
        apply_reset("reset_mid_mem_wait");
        step("after_mem_wait_reset", CTRL_RUN);
    endtask

    task automatic test_timeout();
        apply_reset("timeout_reset");
        MEM_req = 1'b1;
        for (int i = 0; i < MEM_TIMEOUT - 1; i++) step("timeout_wait", CTRL_FROZEN);
        check_counts("timeout_almost");
        checks++;
        if (dbg_state !== MEM_WAIT) begin
            errors++;
            $display("FAIL timeout_state: got %0d expected %0d", dbg_state, MEM_WAIT);
        end
        step("timeout_last", CTRL_FROZEN);
        exp_err = 1'b1;
        step("timeout_halted", CTRL_HALT);
        check_counts("timeout_saturated");
        MEM_req = 1'b0; resume = 1'b1;
        step("timeout_resume", CTRL_HALT);
        resume = 1'b0;
        step("timeout_after_resume", CTRL_RUN);
        check_counts("timeout_err_sticky");
    endtask

    task automatic test_halt();
        apply_reset("halt_reset");
        WB_halt = 1'b1;
        step("wb_halt", CTRL_FROZEN);
        WB_halt = 1'b0;
        for (int i = 0; i < 10; i++) step("halted_hold", CTRL_HALT);
        resume = 1'b1;
        step("halt_resume", CTRL_HALT);
        resume = 1'b0;
        step("halt_resumed", CTRL_RUN);
        check_counts("halt");
        WB_halt = 1'b1;
        step("wb_halt_again", CTRL_FROZEN);
        WB_halt = 1'b0;
        for (int i = 0; i < 3; i++) step("halted_again", CTRL_HALT);
        apply_reset("reset_mid_halt");
        step("after_halt_reset", CTRL_RUN);
        check_counts("after_halt_reset");
    endtask

    initial begin
        exp_stall = '0;
        exp_flush = '0;
        exp_err   = 1'b0;
        clear_inputs();
        @(posedge CLK);
        #1;
        test_reset();
        test_load_use();
        test_mispredict();
        test_mem_wait();
        test_timeout();
        test_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage pipeline. It drives the ENABLE/CLR pins of the IF_ID, ID_EX, EX_MEM and MEM_WB registers and the PC enable. It resolves four conditions by fixed priority: load-use hazards, branch mispredicts, data-memory wait, and halt. It also keeps saturating stall and flush counters for performance measurement.

Parameters:
CNT_W, 32, width of the stall_cycles and flush_events counters.
MEM_TIMEOUT, 16, maximum cycles spent in MEM_WAIT before a memory error is raised (legal range 2..255).

Ports:
CLK  in  1  pipeline clock; all state updates on the rising edge.
RST_N  in  1  asynchronous active-low reset.
ID_rs  in  5  rs field of the instruction in ID.
ID_rt  in  5  rt field of the instruction in ID.
ID_uses_rs  in  1  ID instruction reads rs.
ID_uses_rt  in  1  ID instruction reads rt.
EX_mem_read  in  1  EX instruction is a load.
EX_rd  in  5  destination register of the EX instruction.
EX_mispredict  in  1  branch resolved in EX disagrees with predict_ID; the corrected PC is valid this cycle.
MEM_req  in  1  MEM stage is issuing a data-memory access.
MEM_ack  in  1  data memory completes the access this cycle.
WB_halt  in  1  halt/syscall instruction retiring in WB.
resume  in  1  single-cycle pulse that leaves HALTED.
PC_ENABLE  out  1  PC register load enable.
IF_ID_ENABLE  out  1  IF_ID register enable.
IF_ID_CLR  out  1  IF_ID register clear.
ID_EX_ENABLE  out  1  ID_EX register enable.
ID_EX_CLR  out  1  ID_EX register clear.
EX_MEM_ENABLE  out  1  EX_MEM register enable.
MEM_WB_ENABLE  out  1  MEM_WB register enable.
halted  out  1  controller is in HALTED.
mem_err  out  1  sticky flag: MEM_WAIT timed out.
stall_cycles  out  CNT_W  count of cycles with PC_ENABLE=0 while in RUN or MEM_WAIT.
flush_events  out  CNT_W  count of mispredict flushes.

Behaviour:
- States: RUN, MEM_WAIT, HALTED. State and counters are registered; stage-control outputs are combinational from the state and the current inputs.
- Reset (RST_N=0, asynchronous): state=RUN, wait counter=0, mem_err=0, both counters=0. While reset is held, all ENABLEs=0, IF_ID_CLR=1, ID_EX_CLR=1, halted=0.
- load_use = EX_mem_read && EX_rd!=0 && ((ID_uses_rs && ID_rs==EX_rd) || (ID_uses_rt && ID_rt==EX_rd)).
- Default in RUN: all ENABLEs=1, all CLRs=0.
- RUN priority, highest first:
  1. WB_halt: all ENABLEs=0. Next state is HALTED.
  2. MEM_req && !MEM_ack: all ENABLEs=0, CLRs=0. Next state is MEM_WAIT and the wait counter is set to 1.
  3. EX_mispredict: PC_ENABLE=1, IF_ID_CLR=1, ID_EX_CLR=1, all ENABLEs=1. flush_events increments. Any simultaneous load_use is ignored because its instruction is being flushed.
  4. load_use: PC_ENABLE=0, IF_ID_ENABLE=0, ID_EX_CLR=1 to insert a bubble; the other ENABLEs=1. This lasts exactly 1 cycle, since the next cycle the load is in MEM.
- MEM_req && MEM_ack in the same cycle: no stall.
- MEM_WAIT:
  - All ENABLEs=0, CLRs=0; the pipeline is frozen and EX_mispredict is ignored.
  - MEM_ack: return to RUN and evaluate the RUN rules in that cycle using the default enables. Concretely, the stalled MEM access retires, and hazard outputs follow the normal RUN rules.
  - Otherwise the wait counter increments. When it reaches MEM_TIMEOUT, mem_err is set and the next state is HALTED.
- HALTED: all ENABLEs=0, CLRs=0, halted=1. A resume pulse returns the controller to RUN on the next edge. mem_err is cleared only by reset.
- Counters saturate at 2^CNT_W-1 and do not wrap. stall_cycles counts every cycle in RUN or MEM_WAIT where PC_ENABLE=0. It does not count HALTED or reset cycles.
- Reset asserted mid-MEM_WAIT or mid-HALTED: immediate return to reset values.

Decomposition:
- Shared package pipe_pkg holds:
  - the state encoding (RUN=2'd0, MEM_WAIT=2'd1, HALTED=2'd2);
  - the REG_ZERO constant 5'd0;
  - the default MEM_TIMEOUT.
- One sub-module, sat_counter (parameter width; inputs CLK, RST_N, inc; output count), is instantiated twice for stall_cycles and flush_events.
- The hazard compare stays inline.

Test Plan:
- Reset check: hold RST_N=0 -> all ENABLEs 0, IF_ID_CLR=ID_EX_CLR=1, counters 0. Release with no hazards -> all ENABLEs 1, CLRs 0.
- Load-use on rs: EX_mem_read=1, EX_rd=8, ID_rs=8, ID_uses_rs=1 -> exactly one cycle of PC_ENABLE=0, IF_ID_ENABLE=0, ID_EX_CLR=1; stall_cycles=1. Repeat with EX_rd=0 -> no stall.
- Mispredict together with load-use in the same cycle -> IF_ID_CLR=ID_EX_CLR=1, PC_ENABLE=1, flush_events=1, stall_cycles unchanged.
- MEM_req=1 with MEM_ack arriving 3 cycles later -> 3 frozen cycles (all ENABLEs 0), then RUN; stall_cycles=3.
- MEM_req=1 with ack never asserted, MEM_TIMEOUT=16 -> mem_err=1 and halted=1 after 16 cycles. A resume pulse then returns to RUN with mem_err still 1.
- WB_halt pulse -> halted=1 and ENABLEs 0 held for 10 cycles; resume -> RUN next edge. Assert RST_N low mid-HALTED -> immediate reset values.
